// File: rtl/axil_pkg.sv
// Shared AXI4-Lite definitions: response codes and read-master state encoding.
// The slave-side channels import the same package.
package axil_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        RM_IDLE = 2'b00,
        RM_ADDR = 2'b01,
        RM_DATA = 2'b10,
        RM_RESP = 2'b11
    } rm_state_t;

endpackage

// File: rtl/axil_read_master.sv
// AXI4-Lite read initiator: one outstanding read, bounded SLVERR retry,
// result returned on a valid/ready response port. All outputs registered.
module axil_read_master
    import axil_pkg::*;
#(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_RETRY  = 2,
    parameter int RETRY_W    = 2
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  cmd_valid,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    output logic                  cmd_ready,
    output logic                  ARVALID,
    output logic [ADDR_WIDTH-1:0] ARADDR,
    output logic [2:0]            ARPROT,
    input  logic                  ARREADY,
    input  logic                  RVALID,
    input  logic [DATA_WIDTH-1:0] RDATA,
    input  logic [1:0]            RRESP,
    output logic                  RREADY,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic [1:0]            rsp_resp,
    output logic [RETRY_W-1:0]    rsp_retries,
    input  logic                  rsp_ready
);

    localparam logic [RETRY_W-1:0] RETRY_LIM = RETRY_W'(MAX_RETRY);

    rm_state_t          state;
    logic [RETRY_W-1:0] retry_cnt;

    assign ARPROT = 3'b000;

    // Handshake outputs are updated together with the state so each one is a
    // plain flop that is high exactly while the FSM sits in its phase.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= RM_IDLE;
            cmd_ready   <= 1'b1;
            ARVALID     <= 1'b0;
            ARADDR      <= '0;
            RREADY      <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_data    <= '0;
            rsp_resp    <= RESP_OKAY;
            rsp_retries <= '0;
            retry_cnt   <= '0;
        end else begin
            case (state)
                RM_IDLE: begin
                    if (cmd_valid) begin
                        ARADDR    <= cmd_addr;
                        retry_cnt <= '0;
                        cmd_ready <= 1'b0;
                        ARVALID   <= 1'b1;
                        state     <= RM_ADDR;
                    end
                end
                RM_ADDR: begin
                    if (ARREADY) begin
                        ARVALID <= 1'b0;
                        RREADY  <= 1'b1;
                        state   <= RM_DATA;
                    end
                end
                RM_DATA: begin
                    if (RVALID) begin
                        rsp_data    <= RDATA;
                        rsp_resp    <= RRESP;
                        rsp_retries <= retry_cnt;
                        RREADY      <= 1'b0;
                        if (RRESP == RESP_SLVERR && retry_cnt < RETRY_LIM) begin
                            retry_cnt <= retry_cnt + 1'b1;
                            ARVALID   <= 1'b1;
                            state     <= RM_ADDR;
                        end else begin
                            rsp_valid <= 1'b1;
                            state     <= RM_RESP;
                        end
                    end
                end
                RM_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= RM_IDLE;
                    end
                end
                default: begin
                    cmd_ready <= 1'b1;
                    ARVALID   <= 1'b0;
                    RREADY    <= 1'b0;
                    rsp_valid <= 1'b0;
                    state     <= RM_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axil_read_master.sv
// Randomized bench for axil_read_master: a slave model with random waits,
// a per-command response plan, and a scoreboard fed at command issue.
module tb_axil_read_master;
    import axil_pkg::*;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int MR = 2;
    localparam int RW = 2;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          cmd_valid = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic          cmd_ready;
    logic          ARVALID;
    logic [AW-1:0] ARADDR;
    logic [2:0]    ARPROT;
    logic          ARREADY;
    logic          RVALID;
    logic [DW-1:0] RDATA;
    logic [1:0]    RRESP;
    logic          RREADY;
    logic          rsp_valid;
    logic [DW-1:0] rsp_data;
    logic [1:0]    rsp_resp;
    logic [RW-1:0] rsp_retries;
    logic          rsp_ready;

    axil_read_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_RETRY(MR), .RETRY_W(RW)) dut (
        .clk(clk), .resetn(resetn),
        .cmd_valid(cmd_valid), .cmd_addr(cmd_addr), .cmd_ready(cmd_ready),
        .ARVALID(ARVALID), .ARADDR(ARADDR), .ARPROT(ARPROT), .ARREADY(ARREADY),
        .RVALID(RVALID), .RDATA(RDATA), .RRESP(RRESP), .RREADY(RREADY),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_resp(rsp_resp),
        .rsp_retries(rsp_retries), .rsp_ready(rsp_ready)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [1:0]    resp;
        int            retries;
    } exp_t;

    exp_t          exp_q[$];
    logic [1:0]    plan_resp[MR+1];
    logic [DW-1:0] plan_data[MR+1];
    logic [AW-1:0] cur_addr = '0;
    bit            zero_wait = 0;
    bit            hold_r = 0;
    bit            busy = 0;
    int            ar_cnt = 0;
    int            rsp_seen = 0;
    int            cmd_cyc = 0;
    int            vectors = 0;
    int            miscompares = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Slave model plus protocol checks; samples on negedge, drives after posedge.
    initial begin : env
        bit            pv_ar, pv_rsp, r_pend, ar_hs, r_hs, cmd_hs, rsp_hs;
        logic [AW-1:0] p_addr;
        logic [DW-1:0] p_data;
        logic [1:0]    p_resp;
        logic [RW-1:0] p_ret;
        int            r_dly, idx;
        ARREADY = 0; RVALID = 0; RDATA = '0; RRESP = '0; rsp_ready = 0;
        pv_ar = 0; pv_rsp = 0; r_pend = 0; r_dly = 0;
        p_addr = '0; p_data = '0; p_resp = '0; p_ret = '0;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                r_pend = 0; pv_ar = 0; pv_rsp = 0; busy = 0;
            end else begin
                if (pv_ar) begin
                    check("arvalid_hold", ARVALID, 1);
                    check("araddr_hold", ARADDR, p_addr);
                end
                if (pv_rsp) begin
                    check("rsp_valid_hold", rsp_valid, 1);
                    check("rsp_data_hold", rsp_data, p_data);
                    check("rsp_resp_hold", rsp_resp, p_resp);
                    check("rsp_retries_hold", rsp_retries, p_ret);
                end
                if (busy) check("cmd_ready_busy", cmd_ready, 0);
                if (ARVALID) check("araddr", ARADDR, cur_addr);
                if (RREADY) check("rready_phase", busy && !ARVALID && !rsp_valid && ar_cnt > 0, 1);
                cmd_hs = cmd_valid && cmd_ready;
                ar_hs  = ARVALID && ARREADY;
                r_hs   = RVALID && RREADY;
                rsp_hs = rsp_valid && rsp_ready;
                pv_ar  = ARVALID && !ARREADY;
                pv_rsp = rsp_valid && !rsp_ready;
                p_addr = ARADDR; p_data = rsp_data; p_resp = rsp_resp; p_ret = rsp_retries;
                if (cmd_hs) begin busy = 1; cmd_cyc = cyc; ar_cnt = 0; end
                if (rsp_hs) busy = 0;
                if (r_hs) r_pend = 0;
                if (ar_hs) begin ar_cnt++; r_pend = 1; r_dly = $urandom_range(0, 3); end
            end
            @(posedge clk); #1;
            if (zero_wait) begin
                idx = (ar_cnt > 0) ? ar_cnt - 1 : 0;
                ARREADY = 1; RVALID = 1; rsp_ready = 1;
                RRESP = plan_resp[idx]; RDATA = plan_data[idx];
            end else begin
                ARREADY   = ($urandom_range(0, 2) == 0);
                rsp_ready = ($urandom_range(0, 2) != 0);
                if (!r_pend) RVALID = 0;
                else if (!RVALID && !hold_r) begin
                    if (r_dly == 0) begin
                        RVALID = 1;
                        RRESP = plan_resp[ar_cnt-1];
                        RDATA = plan_data[ar_cnt-1];
                    end else r_dly--;
                end
            end
        end
    end

    // Scoreboard: pops the expected result on every response handshake.
    initial begin : mon
        exp_t e;
        forever begin
            @(negedge clk);
            if (resetn && rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    vectors++; miscompares++;
                    $display("FAIL unexpected_rsp: got data %0h with no command pending", rsp_data);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_data", rsp_data, e.data);
                    check("rsp_resp", rsp_resp, e.resp);
                    check("rsp_retries", rsp_retries, e.retries);
                    check("ar_handshakes", ar_cnt, e.retries + 1);
                    if (zero_wait) check("latency", cyc - cmd_cyc, 3);
                end
                rsp_seen++;
            end
        end
    end

    // Final attempt is the first non-SLVERR beat, or the last allowed one.
    task automatic issue(input logic [AW-1:0] a);
        exp_t e;
        int   n, s0, t;
        n = 0;
        while (n < MR && plan_resp[n] == RESP_SLVERR) n++;
        e.addr = a; e.data = plan_data[n]; e.resp = plan_resp[n]; e.retries = n;
        exp_q.push_back(e);
        s0 = rsp_seen;
        @(posedge clk); #2;
        cmd_valid = 1; cmd_addr = a; cur_addr = a;
        t = 0;
        do begin @(negedge clk); t++; end while (!cmd_ready && t < 100);
        @(posedge clk); #2;
        cmd_valid = 0; cmd_addr = AW'($urandom);
        t = 0;
        while (rsp_seen == s0 && t < 500) begin @(negedge clk); t++; end
        if (rsp_seen == s0) begin
            vectors++; miscompares++;
            $display("FAIL rsp_timeout: no response for addr %0h within 500 cycles", a);
            exp_q.delete();
        end
    endtask

    task automatic rand_plan();
        for (int i = 0; i <= MR; i++) begin
            plan_resp[i] = ($urandom_range(0, 1) == 1) ? RESP_SLVERR : 2'($urandom_range(0, 3));
            plan_data[i] = $urandom;
        end
    endtask

    initial begin : drv
        int t;
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int t;
        for (int i = 0; i <= MR; i++) begin plan_resp[i] = RESP_OKAY; plan_data[i] = '0; end
        #12;
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_arvalid", ARVALID, 0);
        check("rst_rready", RREADY, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_araddr", ARADDR, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_rsp_resp", rsp_resp, 0);
        check("rst_rsp_retries", rsp_retries, 0);
        check("arprot", ARPROT, 0);
        @(posedge clk); #3; resetn = 1;

        zero_wait = 1;
        plan_resp[0] = RESP_OKAY; plan_data[0] = 32'hDEADBEEF;
        issue(5'h0A);
        zero_wait = 0;
        repeat (2) @(posedge clk);

        plan_resp[0] = RESP_SLVERR; plan_data[0] = 32'hBAD0BAD0;
        plan_resp[1] = RESP_OKAY;   plan_data[1] = 32'h00001234;
        issue(5'h11);

        for (int i = 0; i <= MR; i++) begin plan_resp[i] = RESP_SLVERR; plan_data[i] = 32'hE000 + i; end
        issue(5'h1F);

        plan_resp[0] = RESP_DECERR; plan_data[0] = 32'hDECDEC00;
        plan_resp[1] = RESP_OKAY;   plan_data[1] = 32'h0;
        issue(5'h03);

        plan_resp[0] = RESP_EXOKAY; plan_data[0] = 32'hE0E0E0E0;
        issue(5'h00);

        for (int k = 0; k < 150; k++) begin
            rand_plan();
            issue(AW'($urandom));
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end

        // Abandon a transaction while the slave stalls the R channel.
        hold_r = 1;
        rand_plan();
        @(posedge clk); #2;
        cmd_valid = 1; cmd_addr = 5'h15; cur_addr = 5'h15;
        t = 0;
        do begin @(negedge clk); t++; end while (!cmd_ready && t < 100);
        @(posedge clk); #2;
        cmd_valid = 0;
        t = 0;
        while (!RREADY && t < 200) begin @(negedge clk); t++; end
        check("reached_data", RREADY, 1);
        @(posedge clk); #3;
        resetn = 0;
        #1;
        check("async_rready", RREADY, 0);
        check("async_arvalid", ARVALID, 0);
        check("async_rsp_valid", rsp_valid, 0);
        check("async_cmd_ready", cmd_ready, 1);
        repeat (2) @(negedge clk);
        hold_r = 0;
        @(posedge clk); #3;
        resetn = 1;
        @(negedge clk);
        check("post_rst_cmd_ready", cmd_ready, 1);
        check("post_rst_rsp_valid", rsp_valid, 0);
        plan_resp[0] = RESP_OKAY; plan_data[0] = 32'hC0FFEE01;
        issue(5'h07);

        repeat (4) @(posedge clk);
        check("queue_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/axil_read_master.md
Name: axil_read_master

Overview:
AXI4-Lite read initiator. It is the master-side counterpart of the slave read-address channel. It accepts a single-address read command from a local requester, drives the AR handshake, and collects the R beat. It retries SLVERR responses a bounded number of times and returns data plus response code through a valid/ready response port. One transaction is outstanding at a time.

Parameters:
ADDR_WIDTH, 5, width of cmd_addr and ARADDR
DATA_WIDTH, 32, width of RDATA and rsp_data
MAX_RETRY, 2, maximum re-issues after an SLVERR response (0 = never retry)
RETRY_W, 2, width of the retry counter; must satisfy 2^RETRY_W > MAX_RETRY

Ports:
clk  in  1  clock, all logic on rising edge
resetn  in  1  reset, asynchronous, active-low
cmd_valid  in  1  requester has a read command
cmd_addr  in  ADDR_WIDTH  read address, sampled on cmd handshake
cmd_ready  out  1  block idle, command accepted when high with cmd_valid
ARVALID  out  1  read address valid
ARADDR  out  ADDR_WIDTH  read address to slave
ARPROT  out  3  tied 3'b000
ARREADY  in  1  slave accepts address
RVALID  in  1  slave read data valid
RDATA  in  DATA_WIDTH  slave read data
RRESP  in  2  slave read response
RREADY  out  1  master accepts read data
rsp_valid  out  1  response available to requester
rsp_data  out  DATA_WIDTH  captured RDATA of final attempt
rsp_resp  out  2  captured RRESP of final attempt
rsp_retries  out  RETRY_W  number of re-issues performed for this command
rsp_ready  in  1  requester consumes response

Behaviour:
- Reset (async assert, sync release): state=IDLE; ARVALID, RREADY, rsp_valid=0; ARADDR, rsp_data, rsp_resp, rsp_retries, retry count=0. cmd_ready is asserted only in IDLE, so it is 1 after reset.
- All outputs are registered or decoded from the registered state only. No combinational path from any input to any output.
- States, encoded in the package:
  - IDLE
  - ADDR
  - DATA
  - RESP
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&&cmd_ready: latch cmd_addr into ARADDR, clear retry count, go to ADDR.
- ADDR:
  - ARVALID=1. ARADDR held stable. ARVALID never deasserts before ARREADY.
  - On ARREADY sampled high: go to DATA, with ARVALID low the next cycle.
- DATA:
  - RREADY=1.
  - On RVALID: capture RDATA and RRESP.
  - If RRESP==SLVERR and retry count < MAX_RETRY: increment the count and go to ADDR, re-issuing the same ARADDR.
  - Otherwise: go to RESP.
- RESP:
  - rsp_valid=1. rsp_data, rsp_resp and rsp_retries are held stable.
  - On rsp_ready: go to IDLE.
  - The next command cannot be accepted in that same cycle; it is accepted from the following cycle.
- RRESP handling:
  - OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11 (AXI standard encoding).
  - Only SLVERR is retried.
  - DECERR and EXOKAY are reported unmodified without retry.
- Minimum latency with ARREADY and RVALID asserted combinationally-early:
  - cycle 0: cmd handshake
  - cycle 1: ARVALID&&ARREADY
  - cycle 2: RVALID&&RREADY
  - cycle 3: rsp_valid
- Throughput: one command per 4 cycles minimum.
- Retry count saturates at MAX_RETRY. An SLVERR on the final allowed attempt is returned with rsp_resp=2'b10 and rsp_retries=MAX_RETRY.
- RVALID while not in DATA is ignored; RREADY is low, so this is a protocol-legal slave wait.
- ARREADY outside ADDR is ignored.
- cmd_valid outside IDLE is ignored; cmd_ready is low.
- Reset mid-transaction: the transaction is abandoned. All outputs return to reset values immediately, and no response is produced.
- Illegal state encoding: the next state is IDLE.

Decomposition:
- Shared package axil_pkg holds:
  - RESP_OKAY, RESP_EXOKAY, RESP_SLVERR, RESP_DECERR
  - read-master state encodings
- The same package is reused by the slave-side channels.
- Single module. No sub-module is warranted; the retry counter and capture registers stay inline.

Test Plan:
1. Zero-wait read: cmd_addr=5'h0A; ARREADY, RVALID high immediately; RDATA=32'hDEADBEEF, RRESP=00. Required: ARADDR=0x0A in cycle 1, rsp_valid in cycle 3, rsp_data=DEADBEEF, rsp_resp=00, rsp_retries=0.
2. Backpressure: ARREADY delayed 3 cycles, RVALID delayed 2 cycles, rsp_ready delayed 4 cycles. Required: ARVALID/ARADDR stable throughout; RREADY high only in DATA; rsp_* stable until rsp_ready; cmd_ready low the whole time.
3. SLVERR retry: first R beat RRESP=10, second RRESP=00 with RDATA=0x1234. Required: two AR handshakes both with the same ARADDR; rsp_resp=00, rsp_retries=1, rsp_data=0x1234.
4. Retry exhaustion: MAX_RETRY=2, slave always returns SLVERR. Required: exactly 3 AR handshakes; rsp_resp=10, rsp_retries=2.
5. DECERR: RRESP=11 on the first beat. Required: no retry (one AR handshake); rsp_resp=11, rsp_retries=0.
6. Reset mid-op: deassert resetn while in DATA. Required: RREADY, ARVALID, rsp_valid drop asynchronously. After release: cmd_ready=1, and a new command completes normally with rsp_retries=0.
